// File: rtl/rr_arb_mux_4_1.sv
// Four-input round-robin arbiter feeding a one-deep registered output stage.
// Optional per-input grant counters are built when RR_ARB_MUX_GRANT_CNT_EN is defined.
//
// Handshake: a word moves across an interface on a cycle where valid and ready
// are both high at the clock edge. A producer must not make valid depend on ready.
// Once out_valid is high, out_data and out_sel stay stable until out_ready is seen.
module rr_arb_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready,
    output logic [4*8-1:0]     grant_cnt
);

    logic [1:0]       ptr;
    logic [3:0]       grant;
    logic [1:0]       grant_idx;
    logic             any_valid;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] in_word [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign in_word[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // Scan starts at ptr and wraps; the first valid input found wins.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant     = 4'b0000;
        grant_idx = 2'd0;
        found     = 1'b0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    assign any_valid = |in_valid;
    assign load      = ~out_valid | out_ready;
    // Ready is withheld during reset since any word taken then would be dropped.
    assign in_ready  = (load && !rst) ? grant : 4'b0000;
    assign xfer      = load & any_valid & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
        end else if (load) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_word[grant_idx];
                out_sel   <= grant_idx;
                ptr       <= grant_idx + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_MUX_GRANT_CNT_EN
    logic [7:0] cnt [4];

    // Counters stick at 8'hFF rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 8'h00;
            end
        end else if (xfer && cnt[grant_idx] != 8'hFF) begin
            cnt[grant_idx] <= cnt[grant_idx] + 8'h01;
        end
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_cnt_out
        assign grant_cnt[gc*8 +: 8] = cnt[gc];
    end
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
    assign grant_cnt   = '0;
`endif

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed bench for rr_arb_mux_4_1; define RR_ARB_MUX_GRANT_CNT_EN to also
// exercise the grant counters.
module tb_rr_arb_mux_4_1;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst;
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_ready;
    logic [31:0]        grant_cnt;

    int n_pass;
    int n_total;

    rr_arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are read at that point too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Data words per input: A, B, C, D for inputs 0..3.
    function automatic logic [3:0] word_of(input int i);
        logic [15:0] w;
        w = 16'hDCBA;
        return w[i*4 +: 4];
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = 16'hDCBA;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0 || in_ready !== 4'h0)
                $display("FAIL reset_hold cyc%0d out_valid=%b in_ready=%b exp 0/0000", c, out_valid, in_ready);
            else n_pass++;
            n_total++;
            if (out_data !== 4'h0 || out_sel !== 2'd0 || grant_cnt !== 32'h0)
                $display("FAIL reset_vals out_data=%h out_sel=%0d grant_cnt=%h exp 0/0/0", out_data, out_sel, grant_cnt);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 4'b0001) $display("FAIL first_grant_ready in_ready=%b exp 0001", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'hA)
            $display("FAIL first_grant out_valid=%b sel=%0d data=%h exp 1/0/a", out_valid, out_sel, out_data);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_sel [5] = '{1, 2, 3, 0, 1};
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if (in_ready !== 4'(1 << exp_sel[k]))
                $display("FAIL rr_ready step%0d in_ready=%b exp %b", k, in_ready, 4'(1 << exp_sel[k]));
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_sel !== 2'(exp_sel[k]) || out_data !== word_of(exp_sel[k]))
                $display("FAIL rr_out step%0d valid=%b sel=%0d data=%h exp 1/%0d/%h",
                         k, out_valid, out_sel, out_data, exp_sel[k], word_of(exp_sel[k]));
            else n_pass++;
        end
    endtask

    task automatic test_single_input();
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++;
            if (in_ready !== 4'b0100) $display("FAIL single_ready step%0d in_ready=%b exp 0100", k, in_ready);
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'hC)
                $display("FAIL single_out step%0d valid=%b sel=%0d data=%h exp 1/2/c", k, out_valid, out_sel, out_data);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        // Output holds C from input 2; pointer is at 3.
        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (in_ready !== 4'h0) $display("FAIL stall_ready cyc%0d in_ready=%b exp 0000", k, in_ready);
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'hC)
                $display("FAIL stall_hold cyc%0d valid=%b sel=%0d data=%h exp 1/2/c", k, out_valid, out_sel, out_data);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 4'b1000) $display("FAIL stall_release_ready in_ready=%b exp 1000", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'hD)
            $display("FAIL stall_release valid=%b sel=%0d data=%h exp 1/3/d", out_valid, out_sel, out_data);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int exp_sel [4] = '{0, 3, 0, 3};
        in_valid  = 4'b1001;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_sel !== 2'(exp_sel[k]) || out_data !== word_of(exp_sel[k]))
                $display("FAIL wrap step%0d valid=%b sel=%0d data=%h exp 1/%0d/%h",
                         k, out_valid, out_sel, out_data, exp_sel[k], word_of(exp_sel[k]));
            else n_pass++;
        end
    endtask

    task automatic test_idle();
        // Last grant was 3, so the pointer is 0 and must stay there while idle.
        in_valid  = 4'h0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0 || out_sel !== 2'd3 || out_data !== 4'hD)
                $display("FAIL idle_drain cyc%0d valid=%b sel=%0d data=%h exp 0/3/d", k, out_valid, out_sel, out_data);
            else n_pass++;
        end
        out_ready = 1'b0;
        in_valid  = 4'hF;
        #1;
        n_total++;
        if (in_ready !== 4'b0001) $display("FAIL idle_ptr_ready in_ready=%b exp 0001", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'hA)
            $display("FAIL idle_ptr valid=%b sel=%0d data=%h exp 1/0/a", out_valid, out_sel, out_data);
        else n_pass++;
    endtask

    task automatic test_reset_drop();
        // Word from input 0 is stalled; pointer is at 1.
        rst = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0)
            $display("FAIL reset_drop valid=%b sel=%0d data=%h exp 0/0/0", out_valid, out_sel, out_data);
        else n_pass++;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        #1;
        n_total++;
        if (in_ready !== 4'b0001) $display("FAIL reset_drop_ptr in_ready=%b exp 0001", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0)
            $display("FAIL reset_drop_next valid=%b sel=%0d exp 1/0", out_valid, out_sel);
        else n_pass++;
    endtask

    task automatic test_grant_cnt();
`ifdef RR_ARB_MUX_GRANT_CNT_EN
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        n_total++;
        if (grant_cnt !== 32'h0000_0A00) $display("FAIL cnt_partial grant_cnt=%h exp 00000a00", grant_cnt);
        else n_pass++;
        for (int k = 0; k < 290; k++) tick();
        n_total++;
        if (grant_cnt !== 32'h0000_FF00) $display("FAIL cnt_saturate grant_cnt=%h exp 0000ff00", grant_cnt);
        else n_pass++;
`else
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_total++;
        if (grant_cnt !== 32'h0) $display("FAIL cnt_tied grant_cnt=%h exp 00000000", grant_cnt);
        else n_pass++;
`endif
        in_valid = 4'h0;
        tick();
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_valid  = 4'h0;
        in_data   = 16'hDCBA;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single_input();
        test_stall();
        test_wrap();
        test_idle();
        test_reset_drop();
        test_grant_cnt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
